sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 16, sprite ROM address width; DATA_W, 8, ROM word width (palette index); ROM_LAT, 1, cycles from rom_addr presented to rom_q valid (1..3).
REQ-002 Clk  in  1  single clock for all logic.
REQ-003 Reset  in  1  synchronous, active-low reset; sampled only on rising Clk.
REQ-004 frame_clk  in  1  vertical sync level, synchronous to Clk; rising edge marks frame start.
REQ-005 duck_req  in  1  duck requester read request; held until granted.
REQ-006 duck_addr  in  ADDR_W  duck read address; stable while duck_req high.
REQ-007 dog_req  in  1  dog requester read request; held until granted.
REQ-008 dog_addr  in  14  dog read address; zero-extended to ADDR_W.
REQ-009 duck_gnt, dog_gnt  out  1 each  combinational grant, same cycle as accepted request.
REQ-010 rom_addr  out  ADDR_W  registered ROM address.
REQ-011 rom_rd  out  1  registered; high while rom_addr carries a granted read.
REQ-012 rom_q  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_addr/rom_rd.
REQ-013 duck_rdata, dog_rdata  out  DATA_W each  registered returned data.
REQ-014 duck_rvalid, dog_rvalid  out  1 each  registered one-cycle return strobe.
REQ-015 conflict_cnt  out  16  cycles in previous frame with both requests high.

Function
REQ-016 At most one of duck_gnt/dog_gnt high per cycle; a grant is issued only when its req is high.
REQ-017 Single requester: granted in the same cycle, no bubble; back-to-back grants every cycle allowed.
REQ-018 Both requesting: round-robin; grant the requester not granted most recently (last_gnt register, updated only on a grant).
REQ-019 No request: no grant, last_gnt unchanged, rom_rd low next cycle, rom_addr holds previous value.
REQ-020 Grant in cycle N: rom_addr = granted address and rom_rd = 1 in cycle N+1.
REQ-021 Requester tag pipeline depth ROM_LAT+1 tracks each read; rom_q captured at end of cycle N+1+ROM_LAT into the tagged requester's rdata.
REQ-022 Tagged rvalid high exactly in cycle N+2+ROM_LAT (ROM_LAT=1: grant N -> rvalid N+3); other requester's rdata/rvalid untouched.
REQ-023 rdata holds last returned value until overwritten; rvalid low otherwise.
REQ-024 Reads complete in grant order; pipeline never stalls; up to ROM_LAT+1 reads in flight.
REQ-025 Internal conflict counter increments each cycle with duck_req and dog_req both high, saturating at 16'hFFFF.
REQ-026 frame_clk rising edge (registered prior value 0, current 1): conflict_cnt <= counter (including that cycle's increment), counter <= 0 on that cycle; a conflict in the edge cycle counts toward the closing frame.
REQ-027 frame_clk high at reset release is not an edge.

Reset
REQ-028 Reset low at rising Clk: rom_rd, duck_rvalid, dog_rvalid = 0; rom_addr, duck_rdata, dog_rdata, conflict_cnt, counter = 0; last_gnt = dog (duck wins first tie); tag pipeline cleared; frame_clk history = 1.
REQ-029 Reset mid-operation discards all in-flight reads: no rvalid for reads granted before reset.
REQ-030 While Reset low, duck_gnt and dog_gnt = 0 regardless of requests.

Verification
REQ-031 Reset, then duck_req=1, duck_addr=16'h0123 for one cycle N -> duck_gnt=1 in N; rom_addr=16'h0123, rom_rd=1 in N+1; ROM model returns 8'h5A -> duck_rvalid=1, duck_rdata=8'h5A in N+3 only.
REQ-032 Both req held 4 cycles after reset -> grants duck,dog,duck,dog; rvalid sequence matches, each with its own address's data.
REQ-033 dog_req with dog_addr=14'h3FFF -> rom_addr=16'h3FFF; dog_rvalid only, duck outputs unchanged.
REQ-034 Two conflict cycles then frame_clk 0->1 -> conflict_cnt=2 next cycle; next frame with zero conflicts -> conflict_cnt=0 at following edge.
REQ-035 Grant duck in cycle N, Reset low in N+1 -> no duck_rvalid in N+2..N+5; all outputs at reset values.
REQ-036 ROM_LAT=3 build, continuous duck requests addresses 0..7 -> rvalid every cycle from grant+5, data in address order.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: shares one sprite ROM between the duck and dog requesters with
// round-robin tie-breaking, tagged data return and a per-frame conflict counter.
module sprite_rom_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic              duck_req,
    input  logic [ADDR_W-1:0] duck_addr,
    input  logic              dog_req,
    input  logic [13:0]       dog_addr,
    output logic              duck_gnt,
    output logic              dog_gnt,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] duck_rdata,
    output logic [DATA_W-1:0] dog_rdata,
    output logic              duck_rvalid,
    output logic              dog_rvalid,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic {
        GNT_DUCK = 1'b0,
        GNT_DOG  = 1'b1
    } gnt_e;

    gnt_e              r_last_gnt;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_rom_rd;
    logic [ROM_LAT:0]  r_tag_vld;
    logic [ROM_LAT:0]  r_tag_dog;
    logic [DATA_W-1:0] r_duck_rdata;
    logic [DATA_W-1:0] r_dog_rdata;
    logic              r_duck_rvalid;
    logic              r_dog_rvalid;
    logic              r_frame_prev;
    logic [15:0]       r_conf_ctr;
    logic [15:0]       r_conflict_cnt;

    logic              w_duck_gnt;
    logic              w_dog_gnt;
    logic              w_any_gnt;
    logic              w_ret_duck;
    logic              w_ret_dog;
    logic              w_conflict;
    logic              w_frame_rise;
    logic [15:0]       w_conf_next;
    logic [ADDR_W-1:0] w_dog_addr_ext;

    assign w_dog_addr_ext = ADDR_W'(dog_addr);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_duck_gnt = 1'b0;
        w_dog_gnt  = 1'b0;
        if (Reset) begin
            if (duck_req && (!dog_req || r_last_gnt == GNT_DOG)) begin
                w_duck_gnt = 1'b1;
            end else if (dog_req) begin
                w_dog_gnt = 1'b1;
            end
        end
    end

    assign w_any_gnt = w_duck_gnt | w_dog_gnt;

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_last_gnt <= GNT_DOG;
            r_rom_addr <= '0;
            r_rom_rd   <= 1'b0;
        end else begin
            r_rom_rd <= w_any_gnt;
            if (w_duck_gnt) begin
                r_rom_addr <= duck_addr;
                r_last_gnt <= GNT_DUCK;
            end else if (w_dog_gnt) begin
                r_rom_addr <= w_dog_addr_ext;
                r_last_gnt <= GNT_DOG;
            end
        end
    end

    // Tag stage k describes the read whose address left the arbiter k cycles ago;
    // stage ROM_LAT lines up with the matching rom_q word.
    assign w_ret_duck = r_tag_vld[ROM_LAT] & ~r_tag_dog[ROM_LAT];
    assign w_ret_dog  = r_tag_vld[ROM_LAT] &  r_tag_dog[ROM_LAT];

    // NOTE: the tag pipeline is small control state, so it is reset to drop in-flight reads.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_tag_vld     <= '0;
            r_tag_dog     <= '0;
            r_duck_rdata  <= '0;
            r_dog_rdata   <= '0;
            r_duck_rvalid <= 1'b0;
            r_dog_rvalid  <= 1'b0;
        end else begin
            r_tag_vld     <= {r_tag_vld[ROM_LAT-1:0], w_any_gnt};
            r_tag_dog     <= {r_tag_dog[ROM_LAT-1:0], w_dog_gnt};
            r_duck_rvalid <= w_ret_duck;
            r_dog_rvalid  <= w_ret_dog;
            if (w_ret_duck) begin
                r_duck_rdata <= rom_q;
            end
            if (w_ret_dog) begin
                r_dog_rdata <= rom_q;
            end
        end
    end

    assign w_conflict   = duck_req & dog_req;
    assign w_frame_rise = frame_clk & ~r_frame_prev;
    assign w_conf_next  = (w_conflict && r_conf_ctr != 16'hFFFF) ? r_conf_ctr + 16'd1 : r_conf_ctr;

    // The edge cycle's own conflict belongs to the frame that is closing.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_frame_prev   <= 1'b1;
            r_conf_ctr     <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_frame_prev <= frame_clk;
            if (w_frame_rise) begin
                r_conflict_cnt <= w_conf_next;
                r_conf_ctr     <= '0;
            end else begin
                r_conf_ctr <= w_conf_next;
            end
        end
    end

    assign duck_gnt     = w_duck_gnt;
    assign dog_gnt      = w_dog_gnt;
    assign rom_addr     = r_rom_addr;
    assign rom_rd       = r_rom_rd;
    assign duck_rdata   = r_duck_rdata;
    assign dog_rdata    = r_dog_rdata;
    assign duck_rvalid  = r_duck_rvalid;
    assign dog_rvalid   = r_dog_rvalid;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: one ROM_LAT=1 instance for arbitration, return
// and conflict counting, one ROM_LAT=3 instance for the deep-pipeline streaming case.
module tb_sprite_rom_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n   = 1'b0;
    logic        frame_clk = 1'b0;
    logic        duck_req  = 1'b0;
    logic [15:0] duck_addr = '0;
    logic        dog_req   = 1'b0;
    logic [13:0] dog_addr  = '0;
    logic        duck_gnt, dog_gnt, rom_rd, duck_rvalid, dog_rvalid;
    logic [15:0] rom_addr, conflict_cnt;
    logic [7:0]  rom_q, duck_rdata, dog_rdata;

    logic        d3_duck_req  = 1'b0;
    logic [15:0] d3_duck_addr = '0;
    logic        d3_duck_gnt, d3_dog_gnt, d3_rom_rd, d3_duck_rvalid, d3_dog_rvalid;
    logic [15:0] d3_rom_addr, d3_conflict_cnt;
    logic [7:0]  d3_rom_q, d3_duck_rdata, d3_dog_rdata;

    int n_vec = 0;
    int n_err = 0;

    sprite_rom_arbiter u_dut (
        .Clk(clk), .Reset(reset_n), .frame_clk(frame_clk),
        .duck_req(duck_req), .duck_addr(duck_addr), .dog_req(dog_req), .dog_addr(dog_addr),
        .duck_gnt(duck_gnt), .dog_gnt(dog_gnt), .rom_addr(rom_addr), .rom_rd(rom_rd),
        .rom_q(rom_q), .duck_rdata(duck_rdata), .dog_rdata(dog_rdata),
        .duck_rvalid(duck_rvalid), .dog_rvalid(dog_rvalid), .conflict_cnt(conflict_cnt)
    );

    sprite_rom_arbiter #(.ROM_LAT(3)) u_dut3 (
        .Clk(clk), .Reset(reset_n), .frame_clk(1'b0),
        .duck_req(d3_duck_req), .duck_addr(d3_duck_addr), .dog_req(1'b0), .dog_addr(14'h0),
        .duck_gnt(d3_duck_gnt), .dog_gnt(d3_dog_gnt), .rom_addr(d3_rom_addr), .rom_rd(d3_rom_rd),
        .rom_q(d3_rom_q), .duck_rdata(d3_duck_rdata), .dog_rdata(d3_dog_rdata),
        .duck_rvalid(d3_duck_rvalid), .dog_rvalid(d3_dog_rvalid), .conflict_cnt(d3_conflict_cnt)
    );

    // ROM contents: low byte ^ high byte ^ 0x78 (0x0123 -> 0x5A).
    function automatic logic [7:0] rom_word(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h78;
    endfunction

    logic [7:0] rom_pipe;
    logic [7:0] rom3_pipe [3];
    always @(posedge clk) begin
        rom_pipe     <= rom_word(rom_addr);
        rom3_pipe[0] <= rom_word(d3_rom_addr);
        rom3_pipe[1] <= rom3_pipe[0];
        rom3_pipe[2] <= rom3_pipe[1];
    end
    assign rom_q    = rom_pipe;
    assign d3_rom_q = rom3_pipe[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset just released.
    task automatic do_reset();
        reset_n  = 1'b0;
        duck_req = 1'b0;
        dog_req  = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state and single duck read
        do_reset();
        check("rst_rom_rd", rom_rd, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_duck_rvalid", duck_rvalid, 0);
        check("rst_dog_rvalid", dog_rvalid, 0);
        check("rst_duck_rdata", duck_rdata, 0);
        check("rst_dog_rdata", dog_rdata, 0);
        check("rst_conflict_cnt", conflict_cnt, 0);
        duck_req = 1'b1; duck_addr = 16'h0123; #1;
        check("t1_duck_gnt", duck_gnt, 1);
        check("t1_dog_gnt", dog_gnt, 0);
        tick(); duck_req = 1'b0;
        check("t1_rom_addr_n1", rom_addr, 16'h0123);
        check("t1_rom_rd_n1", rom_rd, 1);
        check("t1_rvalid_n1", duck_rvalid, 0);
        tick();
        check("t1_rom_rd_n2", rom_rd, 0);
        check("t1_rom_addr_hold", rom_addr, 16'h0123);
        check("t1_rvalid_n2", duck_rvalid, 0);
        tick();
        check("t1_rvalid_n3", duck_rvalid, 1);
        check("t1_rdata_n3", duck_rdata, 8'h5A);
        check("t1_dog_rvalid_n3", dog_rvalid, 0);
        tick();
        check("t1_rvalid_n4", duck_rvalid, 0);
        check("t1_rdata_hold", duck_rdata, 8'h5A);

        // Dog read at the top of its 14-bit range
        dog_req = 1'b1; dog_addr = 14'h3FFF; #1;
        check("t3_dog_gnt", dog_gnt, 1);
        check("t3_duck_gnt", duck_gnt, 0);
        tick(); dog_req = 1'b0;
        check("t3_rom_addr", rom_addr, 16'h3FFF);
        check("t3_rom_rd", rom_rd, 1);
        tick();
        check("t3_rvalid_m2", dog_rvalid, 0);
        tick();
        check("t3_dog_rvalid", dog_rvalid, 1);
        check("t3_dog_rdata", dog_rdata, 8'hB8);
        check("t3_duck_rvalid", duck_rvalid, 0);
        check("t3_duck_rdata", duck_rdata, 8'h5A);

        // Reset the cycle after a duck grant: the read must vanish
        tick();
        duck_req = 1'b1; duck_addr = 16'h0456; #1;
        check("t5_duck_gnt", duck_gnt, 1);
        tick();
        reset_n = 1'b0; dog_req = 1'b1; #1;
        check("t5_gnt_in_rst_duck", duck_gnt, 0);
        check("t5_gnt_in_rst_dog", dog_gnt, 0);
        tick();
        duck_req = 1'b0; dog_req = 1'b0;
        check("t5_rom_rd", rom_rd, 0);
        check("t5_rom_addr", rom_addr, 0);
        check("t5_duck_rdata", duck_rdata, 0);
        check("t5_dog_rdata", dog_rdata, 0);
        check("t5_rvalid_n2", duck_rvalid, 0);
        tick();
        reset_n = 1'b1;
        check("t5_rvalid_n3", duck_rvalid, 0);
        tick();
        check("t5_rvalid_n4", duck_rvalid, 0);
        tick();
        check("t5_rvalid_n5", duck_rvalid, 0);

        // Both requesting for 4 cycles: duck, dog, duck, dog
        duck_req = 1'b1; duck_addr = 16'h1000;
        dog_req  = 1'b1; dog_addr  = 14'h0200; #1;
        check("t2_c0_duck_gnt", duck_gnt, 1);
        check("t2_c0_dog_gnt", dog_gnt, 0);
        tick(); #1;
        check("t2_c1_dog_gnt", dog_gnt, 1);
        check("t2_c1_duck_gnt", duck_gnt, 0);
        check("t2_c1_rom_addr", rom_addr, 16'h1000);
        tick(); #1;
        check("t2_c2_duck_gnt", duck_gnt, 1);
        check("t2_c2_rom_addr", rom_addr, 16'h0200);
        tick(); #1;
        check("t2_c3_dog_gnt", dog_gnt, 1);
        check("t2_c3_duck_rvalid", duck_rvalid, 1);
        check("t2_c3_duck_rdata", duck_rdata, 8'h68);
        check("t2_c3_dog_rvalid", dog_rvalid, 0);
        tick();
        duck_req = 1'b0; dog_req = 1'b0; #1;
        check("t2_c4_no_gnt", {duck_gnt, dog_gnt}, 0);
        check("t2_c4_rom_rd", rom_rd, 1);
        check("t2_c4_dog_rvalid", dog_rvalid, 1);
        check("t2_c4_dog_rdata", dog_rdata, 8'h7A);
        check("t2_c4_duck_rvalid", duck_rvalid, 0);
        tick();
        check("t2_c5_rom_rd", rom_rd, 0);
        check("t2_c5_duck_rvalid", duck_rvalid, 1);
        check("t2_c5_dog_rvalid", dog_rvalid, 0);
        tick();
        check("t2_c6_dog_rvalid", dog_rvalid, 1);
        check("t2_c6_duck_rvalid", duck_rvalid, 0);
        tick();
        check("t2_c7_rvalids", {duck_rvalid, dog_rvalid}, 0);
        check("t2_c7_conflict_cnt", conflict_cnt, 0);

        // Frame edges: 4 conflicts, then 2 (one in the edge cycle), then 0
        frame_clk = 1'b1;
        tick();
        check("t4_cnt_frame0", conflict_cnt, 4);
        frame_clk = 1'b0;
        tick();
        duck_req = 1'b1; dog_req = 1'b1; #1;
        check("t4_rr_duck", duck_gnt, 1);
        tick();
        frame_clk = 1'b1; #1;
        check("t4_rr_dog", dog_gnt, 1);
        tick();
        duck_req = 1'b0; dog_req = 1'b0;
        check("t4_cnt_frame1", conflict_cnt, 2);
        tick();
        frame_clk = 1'b0;
        check("t4_cnt_hold", conflict_cnt, 2);
        tick();
        tick();
        frame_clk = 1'b1;
        tick();
        check("t4_cnt_frame2", conflict_cnt, 0);

        // frame_clk already high at reset release is not an edge
        do_reset();
        duck_req = 1'b1; dog_req = 1'b1;
        tick();
        check("t027_cnt_r1", conflict_cnt, 0);
        tick();
        duck_req = 1'b0; dog_req = 1'b0; frame_clk = 1'b0;
        tick();
        frame_clk = 1'b1;
        tick();
        check("t027_cnt_edge", conflict_cnt, 2);

        // ROM_LAT=3: streamed duck reads return every cycle from grant+5
        do_reset();
        for (int i = 0; i < 15; i++) begin
            d3_duck_req  = (i < 8);
            d3_duck_addr = 16'(i);
            #1;
            if (i < 8) check($sformatf("t6_gnt_%0d", i), d3_duck_gnt, 1);
            check($sformatf("t6_dog_gnt_%0d", i), d3_dog_gnt, 0);
            check($sformatf("t6_dog_rvalid_%0d", i), d3_dog_rvalid, 0);
            if (i >= 5 && i < 13) begin
                check($sformatf("t6_rvalid_%0d", i), d3_duck_rvalid, 1);
                check($sformatf("t6_rdata_%0d", i), d3_duck_rdata, 8'(8'h78 + i - 5));
            end else begin
                check($sformatf("t6_rvalid_%0d", i), d3_duck_rvalid, 0);
            end
            tick();
        end
        d3_duck_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
